dfs_tree_walker: RTL and testbench

- Depth-first traversal controller for the classifier decision tree. It is the initiator side of the node stack's push/pop interface.
- Given a root node index, it fetches nodes from node memory and pushes each internal node's children onto the external node stack. It pops the next node from that stack and emits every leaf index to the rule-match stage.
- It sits between the lookup front end and the rule-match pipeline. It owns no stack storage.

---
 rtl/tree_pkg.sv | 28 ++
 rtl/dfs_tree_walker.sv | 162 ++++++++++++++++
 tb/tb_dfs_tree_walker.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tree_pkg.sv
// Shared types for the classifier decision-tree walker.
// Default widths, FSM state encoding and the node-memory response layout.
// Imported by the walker and by anything that models node memory.
package tree_pkg;

  localparam int DEF_NODE_W      = 8;
  localparam int DEF_CHILD_CNT_W = 3;
  localparam int DEF_STAT_W      = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    EXPAND  = 3'd3,
    EMIT    = 3'd4,
    POP     = 3'd5,
    POPWAIT = 3'd6,
    DONE    = 3'd7
  } walker_state_e;

  // One node-memory response at the default widths.
  typedef struct packed {
    logic                       is_leaf;
    logic [DEF_NODE_W-1:0]      first_child;
    logic [DEF_CHILD_CNT_W-1:0] num_children;
  } node_resp_t;

endpackage

// File: rtl/dfs_tree_walker.sv
// Purpose: depth-first walk of the decision tree via an external node stack, emitting leaf indices.
// Latency: per node one FETCH cycle plus memory latency; one push per child, pop round trip of 2 cycles.
// Backpressure: holds leaf_valid/leaf_idx stable until leaf_ready; stops with sticky overflow on stk_full.
// Optional: define WALKER_STATS_EN to add nodes_visited / leaves_emitted counters.
module dfs_tree_walker
  import tree_pkg::*;
#(
  parameter int NODE_W      = DEF_NODE_W,
`ifdef WALKER_STATS_EN
  parameter int STAT_W      = DEF_STAT_W,
`endif
  parameter int CHILD_CNT_W = DEF_CHILD_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NODE_W-1:0]      root_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   mem_req,
  output logic [NODE_W-1:0]      mem_addr,
  input  logic                   mem_rvalid,
  input  logic                   mem_is_leaf,
  input  logic [NODE_W-1:0]      mem_first_child,
  input  logic [CHILD_CNT_W-1:0] mem_num_children,
  output logic                   leaf_valid,
  output logic [NODE_W-1:0]      leaf_idx,
  input  logic                   leaf_ready,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [NODE_W-1:0]      stk_wdata,
  input  logic [NODE_W-1:0]      stk_rdata,
  input  logic                   stk_just_popped,
  input  logic                   stk_full,
`ifdef WALKER_STATS_EN
  input  logic                   stk_empty,
  output logic [STAT_W-1:0]      nodes_visited,
  output logic [STAT_W-1:0]      leaves_emitted
`else
  input  logic                   stk_empty
`endif
);

  walker_state_e          state_q, state_d;
  logic [NODE_W-1:0]      cur_node_q;
  logic [NODE_W-1:0]      first_child_q;
  logic [CHILD_CNT_W-1:0] k_q;
  logic                   overflow_q;
  logic [NODE_W-1:0]      child_idx;

  // Child index wraps modulo 2^NODE_W by truncation of the sum.
  assign child_idx = first_child_q + NODE_W'(k_q);
  assign overflow  = overflow_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and Moore-style outputs.
  always_comb begin
    state_d    = state_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    leaf_valid = 1'b0;
    leaf_idx   = '0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_wdata  = '0;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = cur_node_q;
        state_d  = WAIT;
      end
      WAIT: begin
        mem_addr = cur_node_q;
        if (mem_rvalid) begin
          if (mem_is_leaf)                state_d = EMIT;
          else if (mem_num_children == '0) state_d = POP;
          else                            state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (stk_full) begin
          state_d = DONE;
        end else begin
          stk_push  = 1'b1;
          stk_wdata = child_idx;
          if (k_q == '0) state_d = POP;
        end
      end
      EMIT: begin
        leaf_valid = 1'b1;
        leaf_idx   = cur_node_q;
        if (leaf_ready) state_d = POP;
      end
      POP: begin
        if (stk_empty) begin
          state_d = DONE;
        end else begin
          stk_pop = 1'b1;
          state_d = POPWAIT;
        end
      end
      POPWAIT: if (stk_just_popped) state_d = FETCH;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: current node, child expansion counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_node_q    <= '0;
      first_child_q <= '0;
      k_q           <= '0;
      overflow_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cur_node_q <= root_idx;
          overflow_q <= 1'b0;
        end
        WAIT: if (mem_rvalid) begin
          first_child_q <= mem_first_child;
          k_q           <= mem_num_children - CHILD_CNT_W'(1);
        end
        EXPAND: begin
          if (stk_full) overflow_q <= 1'b1;
          else          k_q        <= k_q - CHILD_CNT_W'(1);
        end
        POPWAIT: if (stk_just_popped) cur_node_q <= stk_rdata;
        default: ;
      endcase
    end
  end

`ifdef WALKER_STATS_EN
  // Saturating visit and leaf-transfer counters, cleared per traversal.
  always_ff @(posedge clk) begin
    if (reset || (state_q == IDLE && start)) begin
      nodes_visited  <= '0;
      leaves_emitted <= '0;
    end else begin
      if (state_q == WAIT && mem_rvalid && nodes_visited != '1)
        nodes_visited <= nodes_visited + STAT_W'(1);
      if (state_q == EMIT && leaf_ready && leaves_emitted != '1)
        leaves_emitted <= leaves_emitted + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dfs_tree_walker.sv
// Directed bench for dfs_tree_walker with a node-memory model and a LIFO stack model.
// Each test task drives one scenario and compares against hand-computed values.
// Build with WALKER_STATS_EN defined to also check the statistics counters.
module tb_dfs_tree_walker;
  import tree_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] root_idx;
  logic       busy, done, overflow, mem_req;
  logic [7:0] mem_addr;
  logic       mem_rvalid, mem_is_leaf;
  logic [7:0] mem_first_child;
  logic [2:0] mem_num_children;
  logic       leaf_valid, leaf_ready;
  logic [7:0] leaf_idx;
  logic       stk_push, stk_pop, stk_just_popped, stk_full, stk_empty;
  logic [7:0] stk_wdata, stk_rdata;
`ifdef WALKER_STATS_EN
  logic [15:0] nodes_visited, leaves_emitted;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dfs_tree_walker dut (
    .clk(clk), .reset(reset), .start(start), .root_idx(root_idx),
    .busy(busy), .done(done), .overflow(overflow),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_is_leaf(mem_is_leaf), .mem_first_child(mem_first_child),
    .mem_num_children(mem_num_children),
    .leaf_valid(leaf_valid), .leaf_idx(leaf_idx), .leaf_ready(leaf_ready),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_just_popped(stk_just_popped),
    .stk_full(stk_full),
`ifdef WALKER_STATS_EN
    .stk_empty(stk_empty),
    .nodes_visited(nodes_visited), .leaves_emitted(leaves_emitted)
`else
    .stk_empty(stk_empty)
`endif
  );

  // Node memory model: response mem_lat+1 cycles after the request.
  node_resp_t tree [0:255];
  int         mem_lat = 1;
  bit         pend = 1'b0;
  int         cnt = 0;
  logic [7:0] paddr = '0;
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (reset) begin
      pend <= 1'b0;
    end else if (mem_req) begin
      pend  <= 1'b1;
      cnt   <= mem_lat - 1;
      paddr <= mem_addr;
    end else if (pend) begin
      if (cnt == 0) begin
        mem_rvalid       <= 1'b1;
        mem_is_leaf      <= tree[paddr].is_leaf;
        mem_first_child  <= tree[paddr].first_child;
        mem_num_children <= tree[paddr].num_children;
        pend             <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Node stack model: LIFO, rdata valid one cycle after an accepted pop.
  logic [7:0] stk_mem [0:15];
  int         sp = 0;
  int         stk_depth = 8;
  bit         force_full = 1'b0;
  assign stk_full  = force_full || (sp >= stk_depth);
  assign stk_empty = (sp == 0);
  always @(posedge clk) begin
    stk_just_popped <= 1'b0;
    if (reset) begin
      sp <= 0;
    end else if (stk_push && !stk_full) begin
      stk_mem[sp] <= stk_wdata;
      sp          <= sp + 1;
    end else if (stk_pop && !stk_empty) begin
      stk_rdata       <= stk_mem[sp-1];
      sp              <= sp - 1;
      stk_just_popped <= 1'b1;
    end
  end

  // Transaction logs.
  logic [7:0] push_log[$], leaf_log[$], addr_log[$];
  int done_cnt = 0, both_cnt = 0;
  always @(posedge clk) begin
    if (!reset) begin
      if (stk_push) push_log.push_back(stk_wdata);
      if (mem_req) addr_log.push_back(mem_addr);
      if (leaf_valid && leaf_ready) leaf_log.push_back(leaf_idx);
      if (done) done_cnt++;
      if (stk_push && stk_pop) both_cnt++;
    end
  end

  function automatic string q2s(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) begin
      if (i == 0) s = $sformatf("%0d", q[i]);
      else        s = {s, " ", $sformatf("%0d", q[i])};
    end
    return s;
  endfunction

  task automatic clear_tree();
    for (int i = 0; i < 256; i++) tree[i] = '{is_leaf: 1'b1, first_child: 8'd0, num_children: 3'd0};
  endtask

  task automatic clear_logs();
    push_log.delete(); leaf_log.delete(); addr_log.delete();
    done_cnt = 0; both_cnt = 0;
  endtask

  // Pulse start and wait (bounded) for the done pulse, then step into IDLE.
  task automatic run_walk(input logic [7:0] root, output bit ok);
    @(negedge clk); start = 1'b1; root_idx = root;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL walk_timeout root=%0d: done not seen, required within 500 cycles", root); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; root_idx = 8'd5; leaf_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overflow, mem_req, leaf_valid, stk_push, stk_pop} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0000000", {busy, done, overflow, mem_req, leaf_valid, stk_push, stk_pop});
    end
    checks++;
    if ({mem_addr, leaf_idx, stk_wdata} !== 24'h0) begin
      errors++; $display("FAIL reset_data: got %h required 000000", {mem_addr, leaf_idx, stk_wdata});
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_with_reset: busy=%b required 0", busy); end
  endtask

  task automatic test_leaf_root();
    bit ok;
    clear_tree(); clear_logs();
    run_walk(8'd5, ok);
    checks++;
    if (q2s(leaf_log) != "5") begin errors++; $display("FAIL leaf_root_leaves: got '%s' required '5'", q2s(leaf_log)); end
    checks++;
    if (push_log.size() !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL leaf_root_stack: pushes=%0d done=%0d required 0 and 1", push_log.size(), done_cnt);
    end
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL leaf_root_idle: ovf=%b busy=%b done=%b required 0 0 0", overflow, busy, done);
    end
  endtask

  task automatic test_three_children();
    bit ok;
    clear_tree(); clear_logs();
    tree[0] = '{is_leaf: 1'b0, first_child: 8'd10, num_children: 3'd3};
    run_walk(8'd0, ok);
    checks++;
    if (q2s(push_log) != "12 11 10") begin errors++; $display("FAIL three_pushes: got '%s' required '12 11 10'", q2s(push_log)); end
    checks++;
    if (q2s(leaf_log) != "10 11 12") begin errors++; $display("FAIL three_leaves: got '%s' required '10 11 12'", q2s(leaf_log)); end
    checks++;
    if (both_cnt !== 0 || done_cnt !== 1 || sp !== 0) begin
      errors++; $display("FAIL three_misc: both=%0d done=%0d sp=%0d required 0 1 0", both_cnt, done_cnt, sp);
    end
`ifdef WALKER_STATS_EN
    checks++;
    if (nodes_visited !== 16'd4 || leaves_emitted !== 16'd3) begin
      errors++; $display("FAIL three_stats: visited=%0d leaves=%0d required 4 3", nodes_visited, leaves_emitted);
    end
`endif
  endtask

  task automatic test_two_level();
    bit ok;
    clear_tree(); clear_logs(); mem_lat = 3;
    tree[0] = '{is_leaf: 1'b0, first_child: 8'd1, num_children: 3'd2};
    tree[1] = '{is_leaf: 1'b0, first_child: 8'd3, num_children: 3'd2};
    run_walk(8'd0, ok);
    mem_lat = 1;
    checks++;
    if (q2s(leaf_log) != "3 4 2") begin errors++; $display("FAIL two_level_leaves: got '%s' required '3 4 2'", q2s(leaf_log)); end
    checks++;
    if (q2s(addr_log) != "0 1 3 4 2") begin errors++; $display("FAIL two_level_addrs: got '%s' required '0 1 3 4 2'", q2s(addr_log)); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    clear_tree(); clear_logs();
    leaf_ready = 1'b0;
    @(negedge clk); start = 1'b1; root_idx = 8'd5;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (leaf_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_valid_timeout: leaf_valid not seen, required within 50 cycles"); end
    // Stall four cycles; a start pulse in the middle must be ignored.
    start = 1'b1; root_idx = 8'd9;
    for (int i = 0; i < 4; i++) begin
      if (!(leaf_valid === 1'b1 && leaf_idx === 8'd5)) bad++;
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles required 0", bad); end
    leaf_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (leaf_valid !== 1'b0 || leaf_log.size() !== 1) begin
      errors++; $display("FAIL bp_resume: valid=%b transfers=%0d required 0 1", leaf_valid, leaf_log.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || q2s(addr_log) != "5") begin
      errors++; $display("FAIL bp_done: done=%0d addrs='%s' required 1 '5'", done_cnt, q2s(addr_log));
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_tree(); clear_logs();
    tree[0] = '{is_leaf: 1'b0, first_child: 8'd10, num_children: 3'd3};
    force_full = 1'b1;
    run_walk(8'd0, ok);
    force_full = 1'b0;
    checks++;
    if (push_log.size() !== 0 || leaf_log.size() !== 0) begin
      errors++; $display("FAIL ovf_no_push: pushes=%0d leaves=%0d required 0 0", push_log.size(), leaf_log.size());
    end
    checks++;
    if (overflow !== 1'b1 || done_cnt !== 1) begin
      errors++; $display("FAIL ovf_flag: overflow=%b done=%0d required 1 1", overflow, done_cnt);
    end
    clear_logs();
    run_walk(8'd5, ok);
    checks++;
    if (overflow !== 1'b0 || q2s(leaf_log) != "5") begin
      errors++; $display("FAIL ovf_clear: overflow=%b leaves='%s' required 0 '5'", overflow, q2s(leaf_log));
    end
  endtask

  task automatic test_reset_popwait();
    bit ok;
    clear_tree(); clear_logs();
    tree[0] = '{is_leaf: 1'b0, first_child: 8'd10, num_children: 3'd3};
    @(negedge clk); start = 1'b1; root_idx = 8'd0;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (stk_pop) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_pop_timeout: stk_pop not seen, required within 50 cycles"); end
    @(negedge clk);   // now in POPWAIT
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, overflow, mem_req, leaf_valid, stk_push, stk_pop, mem_addr, leaf_idx, stk_wdata} !== 31'b0) begin
      errors++; $display("FAIL rst_popwait_outputs: busy=%b done=%b mem_req=%b valid=%b required all 0", busy, done, mem_req, leaf_valid);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0 || leaf_log.size() !== 0) begin
      errors++; $display("FAIL rst_popwait_nodone: done=%0d busy=%b leaves=%0d required 0 0 0", done_cnt, busy, leaf_log.size());
    end
  endtask

  task automatic test_wrap_back_to_back();
    bit ok;
    clear_tree(); clear_logs();
    tree[7] = '{is_leaf: 1'b0, first_child: 8'd254, num_children: 3'd3};
    run_walk(8'd7, ok);
    checks++;
    if (q2s(push_log) != "0 255 254") begin errors++; $display("FAIL wrap_pushes: got '%s' required '0 255 254'", q2s(push_log)); end
    checks++;
    if (q2s(leaf_log) != "254 255 0") begin errors++; $display("FAIL wrap_leaves: got '%s' required '254 255 0'", q2s(leaf_log)); end
    clear_logs();
    run_walk(8'd200, ok);
    checks++;
    if (q2s(leaf_log) != "200" || done_cnt !== 1) begin
      errors++; $display("FAIL back_to_back: leaves='%s' done=%0d required '200' 1", q2s(leaf_log), done_cnt);
    end
  endtask

  initial begin
    clear_tree();
    test_reset();
    test_leaf_root();
    test_three_children();
    test_two_level();
    test_backpressure();
    test_overflow();
    test_reset_popwait();
    test_wrap_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
